// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: shared types and helpers for the reset_seq_pf reset sequencer.
//   - reset_seq_state_e : sequencer state encoding (also exposed on dbg_state)
//   - cnt_width()       : width of the shared cycle counter
//   - params_legal()    : parameter legality predicate, checked at elaboration
//                         by reset_seq_pf
// Optional feature macro used by the sequencer: RESET_SEQ_LOCK_LOSS_EN.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    ST_RESET      = 3'd0,
    ST_WAIT_READY = 3'd1,
    ST_RELEASE    = 3'd2,
    ST_RUN        = 3'd3,
    ST_ASSERT     = 3'd4
  } reset_seq_state_e;

  // One counter is shared by the filter, stage delay and assert hold, so it
  // has to hold the largest of the three terminal values.
  function automatic int cnt_width(input int lock_filt, input int stage_dly,
                                   input int min_assert);
    int m;
    m = lock_filt;
    if (stage_dly > m) m = stage_dly;
    if (min_assert > m) m = min_assert;
    return $clog2(m + 1);
  endfunction

  function automatic bit params_legal(input int num_ch, input int sync_stages,
                                      input int lock_filt, input int stage_dly,
                                      input int min_assert);
    return (num_ch >= 1) && (sync_stages >= 2) && (lock_filt >= 1) &&
           (stage_dly >= 1) && (min_assert >= 1);
  endfunction

endpackage

// File: rtl/reset_seq_sync.sv
// reset_seq_sync: STAGES-deep multi-bit synchroniser with asynchronous
// active-low clear. Used both for the async status bus and, with d tied high,
// as a reset-release synchroniser (asserts immediately, releases after STAGES
// rising edges).
// Ports:
//   clk   : sampling clock
//   clr_n : asynchronous active-low clear, forces every stage to 0
//   d     : asynchronous input bus
//   q     : synchronised output bus (last stage)
module reset_seq_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [STAGES];

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/reset_seq_pf.sv
// reset_seq_pf: multi-channel staged reset sequencer.
// Combines external reset, PLL lock, init-done, system-services busy and
// Flash*Freeze restore into NUM_CH active-low fabric resets released in order
// (channel 0 first) with STAGE_DLY cycles between channels.
// Ports:
//   CLK            : single clock, rising edge
//   EXT_RST_N      : async active-low reset, async assert / synchronised release
//   PLL_LOCK       : async, synchronised
//   INIT_DONE      : async, synchronised
//   SS_BUSY        : async, synchronised, high pauses progress
//   FF_US_RESTORE  : async, synchronised, high freezes the whole sequencer
//   SW_RST_REQ     : CLK-synchronous one-cycle re-sequence request
//   FABRIC_RESET_N : registered active-low channel resets
//   RESET_DONE     : high once every channel is released
//   dbg_state      : current sequencer state (reset_seq_state_e encoding)
// Optional feature: define RESET_SEQ_LOCK_LOSS_EN to make loss of PLL lock in
// RELEASE/RUN force a full re-sequence; otherwise lock only gates WAIT_READY
// and pauses RELEASE.
import reset_seq_pkg::*;

module reset_seq_pf #(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_FILT   = 8,
  parameter int STAGE_DLY   = 16,
  parameter int MIN_ASSERT  = 32
) (
  input  logic              CLK,
  input  logic              EXT_RST_N,
  input  logic              PLL_LOCK,
  input  logic              INIT_DONE,
  input  logic              SS_BUSY,
  input  logic              FF_US_RESTORE,
  input  logic              SW_RST_REQ,
  output logic [NUM_CH-1:0] FABRIC_RESET_N,
  output logic              RESET_DONE,
  output logic [2:0]        dbg_state
);

  if (!params_legal(NUM_CH, SYNC_STAGES, LOCK_FILT, STAGE_DLY, MIN_ASSERT)) begin : g_bad_params
    $error("reset_seq_pf: illegal parameter set");
  end

  localparam int CW = cnt_width(LOCK_FILT, STAGE_DLY, MIN_ASSERT);
  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [CW-1:0] FILT_DONE = CW'(LOCK_FILT);
  localparam logic [CW-1:0] DLY_LAST  = CW'(STAGE_DLY - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(MIN_ASSERT - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_CH - 1);
  localparam logic [IW-1:0] FIRST_NXT = (NUM_CH > 1) ? IW'(1) : '0;

  logic             int_rst_n;
  logic [3:0]       status_s;
  logic             pll_lock_s, init_done_s, ss_busy_s, ff_restore_s;
  logic             ready, pause, lock_loss;
  reset_seq_state_e state;
  logic [CW-1:0]    cnt;
  logic [IW-1:0]    idx;  // next channel to release
  logic [NUM_CH-1:0] fab;
  logic             done;

  reset_seq_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_rst_sync (
    .clk(CLK), .clr_n(EXT_RST_N), .d(1'b1), .q(int_rst_n)
  );

  // Status bus is held cleared until internal reset releases so stale values
  // captured during reset can never count toward the lock filter.
  reset_seq_sync #(.WIDTH(4), .STAGES(SYNC_STAGES)) u_status_sync (
    .clk(CLK), .clr_n(int_rst_n),
    .d({FF_US_RESTORE, SS_BUSY, INIT_DONE, PLL_LOCK}), .q(status_s)
  );

  assign {ff_restore_s, ss_busy_s, init_done_s, pll_lock_s} = status_s;
  assign ready = pll_lock_s & init_done_s & ~ss_busy_s;

`ifdef RESET_SEQ_LOCK_LOSS_EN
  assign lock_loss = ~pll_lock_s;
  assign pause     = ss_busy_s;
`else
  assign lock_loss = 1'b0;
  assign pause     = ss_busy_s | ~pll_lock_s;
`endif

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + 1'b1;
  endfunction

  // EXT_RST_N clears the outputs directly so they drop in zero cycles; the
  // synchronised int_rst_n only governs when sequencing may begin.
  always_ff @(posedge CLK or negedge EXT_RST_N) begin
    if (!EXT_RST_N) begin
      state <= ST_RESET;
      cnt   <= '0;
      idx   <= '0;
      fab   <= '0;
      done  <= 1'b0;
    end else if (!int_rst_n) begin
      state <= ST_RESET;
      cnt   <= '0;
      idx   <= '0;
      fab   <= '0;
      done  <= 1'b0;
    end else if (!ff_restore_s) begin
      case (state)
        ST_RESET: begin
          state <= ST_WAIT_READY;
          cnt   <= '0;
        end
        ST_WAIT_READY: begin
          if (SW_RST_REQ) begin
            state <= ST_ASSERT; fab <= '0; done <= 1'b0; cnt <= '0; idx <= '0;
          end else if (!ready) begin
            cnt <= '0;
          end else if (cnt == FILT_DONE) begin
            fab[0] <= 1'b1;
            idx    <= FIRST_NXT;
            cnt    <= '0;
            state  <= ST_RELEASE;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        ST_RELEASE: begin
          if (SW_RST_REQ || lock_loss) begin
            state <= ST_ASSERT; fab <= '0; done <= 1'b0; cnt <= '0; idx <= '0;
          end else if (fab[NUM_CH-1]) begin
            // Last channel went high on the previous edge.
            state <= ST_RUN;
            done  <= 1'b1;
          end else if (!pause) begin
            if (cnt == DLY_LAST) begin
              fab[idx] <= 1'b1;
              cnt      <= '0;
              if (idx != LAST_IDX) idx <= idx + 1'b1;
            end else begin
              cnt <= sat_inc(cnt);
            end
          end
        end
        ST_RUN: begin
          if (SW_RST_REQ || lock_loss) begin
            state <= ST_ASSERT; fab <= '0; done <= 1'b0; cnt <= '0; idx <= '0;
          end
        end
        ST_ASSERT: begin
          if (SW_RST_REQ) begin
            cnt <= '0;  // a fresh request restarts the hold
          end else if (cnt == HOLD_LAST) begin
            state <= ST_WAIT_READY;
            cnt   <= '0;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        default: begin
          state <= ST_RESET; fab <= '0; done <= 1'b0; cnt <= '0; idx <= '0;
        end
      endcase
    end
  end

  assign FABRIC_RESET_N = fab;
  assign RESET_DONE     = done;
  assign dbg_state      = state;

endmodule

// File: tb/tb_reset_seq_pf.sv
// tb_reset_seq_pf: directed self-checking bench for reset_seq_pf with
// NUM_CH=4, SYNC_STAGES=2, LOCK_FILT=8, STAGE_DLY=16, MIN_ASSERT=32.
// Expected latencies are hand-derived edge counts. Honours
// RESET_SEQ_LOCK_LOSS_EN when the same macro is defined for the DUT.
module tb_reset_seq_pf;
  import reset_seq_pkg::*;

  localparam int BUDGET = 200;

  logic       CLK, EXT_RST_N, PLL_LOCK, INIT_DONE, SS_BUSY, FF_US_RESTORE, SW_RST_REQ;
  logic [3:0] FABRIC_RESET_N;
  logic       RESET_DONE;
  logic [2:0] dbg_state;

  int tests_run    = 0;
  int tests_failed = 0;

  reset_seq_pf #(
    .NUM_CH(4), .SYNC_STAGES(2), .LOCK_FILT(8), .STAGE_DLY(16), .MIN_ASSERT(32)
  ) dut (
    .CLK(CLK), .EXT_RST_N(EXT_RST_N), .PLL_LOCK(PLL_LOCK), .INIT_DONE(INIT_DONE),
    .SS_BUSY(SS_BUSY), .FF_US_RESTORE(FF_US_RESTORE), .SW_RST_REQ(SW_RST_REQ),
    .FABRIC_RESET_N(FABRIC_RESET_N), .RESET_DONE(RESET_DONE), .dbg_state(dbg_state)
  );

  // clock / reset block
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Count rising edges until channel sel (0..3) or RESET_DONE (sel==4) is high.
  task automatic wait_sig(input int sel, output int n);
    logic hit;
    n = 0;
    do begin
      @(posedge CLK); #1;
      n++;
      hit = (sel < 4) ? FABRIC_RESET_N[sel] : RESET_DONE;
    end while (!hit && n < BUDGET);
  endtask

  task automatic wait_state(input logic [2:0] st, output int n);
    n = 0;
    do begin
      @(posedge CLK); #1;
      n++;
    end while (dbg_state != st && n < BUDGET);
  endtask

  task automatic test_reset();
    EXT_RST_N = 1'b0; PLL_LOCK = 1'b1; INIT_DONE = 1'b1; SS_BUSY = 1'b0;
    FF_US_RESTORE = 1'b0; SW_RST_REQ = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    tests_run++;
    if (FABRIC_RESET_N !== 4'h0) begin
      $display("FAIL reset_fab: got %h expected %h", FABRIC_RESET_N, 4'h0); tests_failed++;
    end
    tests_run++;
    if (RESET_DONE !== 1'b0) begin
      $display("FAIL reset_done: got %b expected 0", RESET_DONE); tests_failed++;
    end
    tests_run++;
    if (dbg_state !== ST_RESET) begin
      $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_RESET); tests_failed++;
    end
  endtask

  // Tail of a release sequence: channels 1..3 at 16-cycle spacing, done +1.
  task automatic check_tail(input string tag, input int first_ch);
    int n;
    for (int ch = first_ch; ch < 4; ch++) begin
      wait_sig(ch, n);
      tests_run++;
      if (n !== 16) begin
        $display("FAIL %s_ch%0d: got %0d cycles expected 16", tag, ch, n); tests_failed++;
      end
    end
    wait_sig(4, n);
    tests_run++;
    if (n !== 1 || FABRIC_RESET_N !== 4'hf) begin
      $display("FAIL %s_done: got %0d cycles fab %h expected 1 cycle fab f", tag, n, FABRIC_RESET_N);
      tests_failed++;
    end
  endtask

  task automatic test_powerup();
    int n;
    @(negedge CLK) EXT_RST_N = 1'b1;
    // int reset releases at edge 2, WAIT_READY entered at edge 3
    wait_state(ST_WAIT_READY, n);
    tests_run++;
    if (n !== 3) begin
      $display("FAIL powerup_wait_entry: got %0d expected 3", n); tests_failed++;
    end
    // status sync valid after edge 4, filter counts edges 5..12, release edge 13
    wait_sig(0, n);
    tests_run++;
    if (n !== 10) begin
      $display("FAIL powerup_ch0: got %0d expected 10", n); tests_failed++;
    end
    check_tail("powerup", 1);
    tests_run++;
    if (dbg_state !== ST_RUN) begin
      $display("FAIL powerup_run: got %0d expected %0d", dbg_state, ST_RUN); tests_failed++;
    end
  endtask

  task automatic test_sw_req();
    int n;
    @(negedge CLK) SW_RST_REQ = 1'b1;
    @(posedge CLK); #1;
    tests_run++;
    if (FABRIC_RESET_N !== 4'h0 || RESET_DONE !== 1'b0 || dbg_state !== ST_ASSERT) begin
      $display("FAIL swreq_assert: fab %h done %b state %0d expected fab 0 done 0 state %0d",
               FABRIC_RESET_N, RESET_DONE, dbg_state, ST_ASSERT);
      tests_failed++;
    end
    @(negedge CLK) SW_RST_REQ = 1'b0;
    // second request 10 cycles into the hold restarts the 32-cycle count
    repeat (9) @(posedge CLK);
    @(negedge CLK) SW_RST_REQ = 1'b1;
    @(negedge CLK) SW_RST_REQ = 1'b0;
    wait_state(ST_WAIT_READY, n);
    tests_run++;
    if (n !== 32 || FABRIC_RESET_N !== 4'h0) begin
      $display("FAIL swreq_hold: got %0d cycles fab %h expected 32 cycles fab 0", n, FABRIC_RESET_N);
      tests_failed++;
    end
    wait_sig(0, n);
    tests_run++;
    if (n !== 9) begin
      $display("FAIL swreq_ch0: got %0d expected 9", n); tests_failed++;
    end
    check_tail("swreq", 1);
  endtask

  task automatic test_lock_loss();
    int n;
    @(negedge CLK) PLL_LOCK = 1'b0;
`ifdef RESET_SEQ_LOCK_LOSS_EN
    n = 0;
    do begin
      @(posedge CLK); #1;
      n++;
    end while (FABRIC_RESET_N === 4'hf && n < 10);
    tests_run++;
    if (n !== 3 || FABRIC_RESET_N !== 4'h0 || RESET_DONE !== 1'b0) begin
      $display("FAIL lockloss_drop: got %0d cycles fab %h expected 3 cycles fab 0", n, FABRIC_RESET_N);
      tests_failed++;
    end
    @(negedge CLK) PLL_LOCK = 1'b1;
    // 32 hold + 9 filter + 48 staging + 1 done
    wait_sig(4, n);
    tests_run++;
    if (n !== 90) begin
      $display("FAIL lockloss_reseq: got %0d expected 90", n); tests_failed++;
    end
`else
    repeat (10) @(posedge CLK);
    #1;
    tests_run++;
    if (FABRIC_RESET_N !== 4'hf || RESET_DONE !== 1'b1) begin
      $display("FAIL lockloss_ignored: fab %h done %b expected fab f done 1", FABRIC_RESET_N, RESET_DONE);
      tests_failed++;
    end
    @(negedge CLK) PLL_LOCK = 1'b1;
    repeat (4) @(posedge CLK);
`endif
  endtask

  task automatic test_filter_restart();
    int n;
    @(negedge CLK) EXT_RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    EXT_RST_N = 1'b1;
    // lock low for edge 8 only: filter sees it at edge 10 (count 5), restarts,
    // counts 1..8 at edges 11..18 and releases at edge 19
    repeat (7) @(negedge CLK);
    PLL_LOCK = 1'b0;
    @(negedge CLK) PLL_LOCK = 1'b1;
    wait_sig(0, n);
    tests_run++;
    if (n !== 11) begin
      $display("FAIL filter_ch0: got %0d expected 11", n); tests_failed++;
    end
  endtask

  task automatic test_busy();
    int n;
    wait_sig(1, n);
    tests_run++;
    if (n !== 16) begin
      $display("FAIL busy_ch1: got %0d expected 16", n); tests_failed++;
    end
    @(negedge CLK) SS_BUSY = 1'b1;
    repeat (10) @(negedge CLK);
    SS_BUSY = 1'b0;
    tests_run++;
    if (FABRIC_RESET_N !== 4'h3) begin
      $display("FAIL busy_hold: got %h expected 3", FABRIC_RESET_N); tests_failed++;
    end
    wait_sig(2, n);
    tests_run++;
    if (n + 10 !== 26) begin
      $display("FAIL busy_ch2: got %0d expected 26", n + 10); tests_failed++;
    end
    check_tail("busy", 3);
  endtask

  task automatic test_freeze();
    int n;
    @(negedge CLK) EXT_RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    EXT_RST_N = 1'b1;
    wait_sig(0, n);
    tests_run++;
    if (n !== 13) begin
      $display("FAIL freeze_ch0: got %0d expected 13", n); tests_failed++;
    end
    @(negedge CLK) FF_US_RESTORE = 1'b1;
    repeat (9) @(negedge CLK);
    SW_RST_REQ = 1'b1;            // arrives while frozen: must be dropped
    @(negedge CLK) SW_RST_REQ = 1'b0;
    repeat (4) @(negedge CLK);
    tests_run++;
    if (FABRIC_RESET_N !== 4'h1 || dbg_state !== ST_RELEASE || RESET_DONE !== 1'b0) begin
      $display("FAIL freeze_hold: fab %h state %0d expected fab 1 state %0d",
               FABRIC_RESET_N, dbg_state, ST_RELEASE);
      tests_failed++;
    end
    repeat (6) @(negedge CLK);
    FF_US_RESTORE = 1'b0;
    wait_sig(1, n);
    tests_run++;
    if (n + 20 !== 36) begin
      $display("FAIL freeze_ch1: got %0d expected 36", n + 20); tests_failed++;
    end
  endtask

  task automatic test_ext_reset_mid();
    int n;
    wait_sig(2, n);
    tests_run++;
    if (n !== 16) begin
      $display("FAIL extmid_ch2: got %0d expected 16", n); tests_failed++;
    end
    @(posedge CLK);
    #2 EXT_RST_N = 1'b0;
    #1;
    tests_run++;
    if (FABRIC_RESET_N !== 4'h0 || RESET_DONE !== 1'b0 || dbg_state !== ST_RESET) begin
      $display("FAIL extmid_async: fab %h done %b state %0d expected fab 0 done 0 state %0d",
               FABRIC_RESET_N, RESET_DONE, dbg_state, ST_RESET);
      tests_failed++;
    end
  endtask

  initial begin
    test_reset();
    test_powerup();
    test_sw_req();
    test_lock_loss();
    test_filter_restart();
    test_busy();
    test_freeze();
    test_ext_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
